// File: rtl/mem_copier.sv
// Memory-to-memory word copier on a single-port RAM with 1-cycle read latency.
// Optional MEM_COPIER_FILL_EN adds a pattern-fill mode (i_fill/i_pattern).
module mem_copier #(
  parameter int unsigned PBITS = 32,
  parameter int unsigned DBITS = 32,
  parameter int unsigned LBITS = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [PBITS-1:0] i_src,
  input  logic [PBITS-1:0] i_dst,
  input  logic [LBITS-1:0] i_len,
`ifdef MEM_COPIER_FILL_EN
  input  logic             i_fill,
  input  logic [DBITS-1:0] i_pattern,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_m_en,
  output logic             o_m_we,
  output logic [PBITS-1:0] o_m_addr,
  output logic [DBITS-1:0] o_m_wdata,
  input  logic [DBITS-1:0] i_m_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StWr,
    StFin
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PBITS-1:0] r_sa;
  logic [PBITS-1:0] r_da;
  logic [LBITS-1:0] r_cnt;
  logic [DBITS-1:0] r_hold;
  logic             w_fill_mode;
  logic             w_start_fill;

`ifdef MEM_COPIER_FILL_EN
  logic r_fill;

  assign w_fill_mode  = r_fill;
  assign w_start_fill = i_fill;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fill <= 1'b0;
    end else if (r_state == StIdle && i_start) begin
      r_fill <= i_fill;
    end
  end
`else
  assign w_fill_mode  = 1'b0;
  assign w_start_fill = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          if (i_len == '0) begin
            w_state_next = StFin;
          end else if (w_start_fill) begin
            w_state_next = StWr;
          end else begin
            w_state_next = StRd;
          end
        end
      end
      StRd:  w_state_next = StCap;
      StCap: w_state_next = StWr;
      StWr: begin
        // r_cnt is the pre-decrement count, so 1 means this is the last word.
        if (r_cnt == LBITS'(1)) begin
          w_state_next = StFin;
        end else if (w_fill_mode) begin
          w_state_next = StWr;
        end else begin
          w_state_next = StRd;
        end
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sa   <= '0;
      r_da   <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_sa  <= i_src;
            r_da  <= i_dst;
            r_cnt <= i_len;
`ifdef MEM_COPIER_FILL_EN
            if (i_fill) begin
              r_hold <= i_pattern;
            end
`endif
          end
        end
        StCap: r_hold <= i_m_rdata;
        StWr: begin
          r_sa  <= r_sa + PBITS'(1);
          r_da  <= r_da + PBITS'(1);
          r_cnt <= r_cnt - LBITS'(1);
        end
        default: ;
      endcase
    end
  end

  // Port controls decode from registered state only, so reset clears them at once.
  always_comb begin
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_m_en    = 1'b0;
    o_m_we    = 1'b0;
    o_m_addr  = '0;
    o_m_wdata = '0;
    unique case (r_state)
      StRd: begin
        o_busy   = 1'b1;
        o_m_en   = 1'b1;
        o_m_addr = r_sa;
      end
      StCap: o_busy = 1'b1;
      StWr: begin
        o_busy    = 1'b1;
        o_m_en    = 1'b1;
        o_m_we    = 1'b1;
        o_m_addr  = r_da;
        o_m_wdata = r_hold;
      end
      StFin:   o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copier.sv
// Scoreboard bench for mem_copier: expected bus accesses queued at stimulus, checked at negedge.
module tb_mem_copier;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic        fill = 1'b0;
  logic [31:0] pattern = '0;
  logic        busy, done, m_en, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  acc_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;

  mem_copier #(.PBITS(32), .DBITS(32), .LBITS(16)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_src     (src),
    .i_dst     (dst),
    .i_len     (len),
`ifdef MEM_COPIER_FILL_EN
    .i_fill    (fill),
    .i_pattern (pattern),
`endif
    .o_busy    (busy),
    .o_done    (done),
    .o_m_en    (m_en),
    .o_m_we    (m_we),
    .o_m_addr  (m_addr),
    .o_m_wdata (m_wdata),
    .i_m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory model: 1-cycle read latency, write on enable edge.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[11:0]] <= m_wdata;
      else m_rdata <= mem[m_addr[11:0]];
    end
  end

  always @(negedge clk) begin
    acc_t e;
    if (done) done_cnt <= done_cnt + 1;
    if (m_en) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_access", {m_we, m_addr}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check_eq("acc_we", m_we, e.we);
        check_eq("acc_addr", m_addr, e.addr);
        if (e.we) check_eq("acc_wdata", m_wdata, e.data);
      end
    end
  end

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    mem[a[11:0]]     = d;
    ref_mem[a[11:0]] = d;
  endtask

  // Queues the expected access sequence, runs the transfer and checks busy/done per cycle.
  // intr_cyc != 0 pulses a stray start in that cycle, which must be ignored.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input logic fl, input logic [31:0] pat, input int intr_cyc);
    int          exp_done;
    int          dones0;
    logic [31:0] a;
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      a = s + 32'(i);
      v = fl ? pat : ref_mem[a[11:0]];
      if (!fl) exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
      a = d + 32'(i);
      exp_q.push_back('{we: 1'b1, addr: a, data: v});
      ref_mem[a[11:0]] = v;
    end
    exp_done = (n == 0) ? 1 : (fl ? n + 1 : 3 * n + 1);
    dones0   = done_cnt;
    @(negedge clk);
    start   = 1'b1;
    src     = s;
    dst     = d;
    len     = 16'(n);
    fill    = fl;
    pattern = pat;
    for (int c = 1; c <= exp_done; c++) begin
      @(negedge clk);
      start = (c == intr_cyc);
      src   = 32'h5000;
      dst   = 32'h6000;
      len   = 16'd7;
      check_eq($sformatf("busy_c%0d", c), busy, c < exp_done);
      check_eq($sformatf("done_c%0d", c), done, c == exp_done);
    end
    @(negedge clk);
    start = 1'b0;
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_en", m_en, 1'b0);
    check_eq("done_count", done_cnt - dones0, 1);
    check_eq("queue_drained", exp_q.size(), 0);
    for (int i = 0; i < n; i++) begin
      a = d + 32'(i);
      check_eq($sformatf("mem_%0h", a), mem[a[11:0]], ref_mem[a[11:0]]);
    end
  endtask

  initial begin
    int dones0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_en", m_en, 1'b0);
    check_eq("rst_we", m_we, 1'b0);
    check_eq("rst_addr", m_addr, 32'h0);
    check_eq("rst_wdata", m_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic 4-word copy, done at cycle 13.
    for (int i = 0; i < 4; i++) poke(32'h100 + 32'(i), 32'(i + 1));
    run_copy(32'h100, 32'h200, 4, 1'b0, 32'h0, 0);

    // Zero length: no bus activity, done the cycle after start.
    run_copy(32'h100, 32'h220, 0, 1'b0, 32'h0, 0);
    check_eq("len0_untouched", mem[12'h220], 32'h0);

    // Address wrap at the top of the space.
    poke(32'hFFFF_FFFF, 32'hCAFE_0001);
    poke(32'h0, 32'hCAFE_0002);
    run_copy(32'hFFFF_FFFF, 32'h10, 2, 1'b0, 32'h0, 0);

    // Stray start while busy, then one during FIN.
    run_copy(32'h100, 32'h240, 4, 1'b0, 32'h0, 5);
    run_copy(32'h100, 32'h260, 2, 1'b0, 32'h0, 7);

    // Overlapping ascending copy smears the first word forward.
    for (int i = 0; i < 4; i++) poke(32'h500 + 32'(i), 32'h77 + 32'(i));
    run_copy(32'h500, 32'h501, 3, 1'b0, 32'h0, 0);

    // Reset during the write of word 2 of 4.
    for (int i = 0; i < 4; i++) poke(32'h300 + 32'(i), 32'hA0 + 32'(i));
    exp_q.push_back('{we: 1'b0, addr: 32'h300, data: 32'h0});
    exp_q.push_back('{we: 1'b1, addr: 32'h380, data: 32'hA0});
    exp_q.push_back('{we: 1'b0, addr: 32'h301, data: 32'h0});
    ref_mem[12'h380] = 32'hA0;
    dones0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    src   = 32'h300;
    dst   = 32'h380;
    len   = 16'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    check_eq("pre_rst_we", m_we, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("midrst_en", m_en, 1'b0);
    check_eq("midrst_we", m_we, 1'b0);
    check_eq("midrst_addr", m_addr, 32'h0);
    check_eq("midrst_wdata", m_wdata, 32'h0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_no_done", done_cnt - dones0, 0);
    check_eq("midrst_word1", mem[12'h380], 32'hA0);
    check_eq("midrst_word2_unwritten", mem[12'h381], 32'h0);
    check_eq("midrst_queue", exp_q.size(), 0);
    run_copy(32'h300, 32'h380, 4, 1'b0, 32'h0, 0);

`ifdef MEM_COPIER_FILL_EN
    run_copy(32'h0, 32'h40, 3, 1'b1, 32'hDEAD_BEEF, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
